vec_issue_controller: RTL

//  Per-instruction sequencer for the vector datapath. Accepts one instruction at a time from the scalar core

---
 rtl/vec_ctrl_pkg.sv | 39 +++
 rtl/vec_ctrl_decode.sv | 48 ++++
 rtl/vec_issue_controller.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/vec_ctrl_pkg.sv
// Shared types and encodings for the vector issue controller slice.
package vec_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_CFG,
    S_EXEC,
    S_WB,
    S_DONE
  } vec_state_e;

  localparam logic [6:0] OP_V = 7'b1010111;

  localparam logic [2:0] F3_OPIVV = 3'b000;
  localparam logic [2:0] F3_OPMVV = 3'b010;
  localparam logic [2:0] F3_OPIVI = 3'b011;
  localparam logic [2:0] F3_OPIVX = 3'b100;
  localparam logic [2:0] F3_OPMVX = 3'b110;
  localparam logic [2:0] F3_OPCFG = 3'b111;

  localparam logic [1:0] MUX1_VS1  = 2'b00;
  localparam logic [1:0] MUX1_SCAL = 2'b01;
  localparam logic [1:0] MUX1_IMM  = 2'b10;
  localparam logic       MUX2_VS2  = 1'b0;
  localparam logic       MUX2_SCAL = 1'b1;

  typedef struct packed {
    logic       vl_sel;
    logic       vtype_sel;
    logic       lumop_sel;
    logic       rs1rd_de;
    logic       rs1_sel;
    logic       mask_operation;
    logic [1:0] data_mux1_sel;
    logic       data_mux2_sel;
  } vec_ctrl_t;

endpackage

// File: rtl/vec_ctrl_decode.sv
// Combinational decode of the latched instruction into datapath selects.
module vec_ctrl_decode
  import vec_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output vec_ctrl_t   ctrl,
  output logic        is_cfg,
  output logic        is_opv
);

  logic [2:0] funct3;
  logic [4:0] rs1;
  logic       unused_bits;

  assign funct3      = inst[14:12];
  assign rs1         = inst[19:15];
  assign is_opv      = (inst[6:0] == OP_V);
  assign is_cfg      = (funct3 == F3_OPCFG);
  assign unused_bits = ^{inst[25:20], inst[11:7]};

  always_comb begin
    ctrl = '0;
    if (is_cfg) begin
      ctrl.rs1_sel  = 1'b1;
      ctrl.rs1rd_de = (rs1 == 5'd0);
      // inst[31]=0 vsetvli, 11 vsetivli, otherwise vsetvl
      if (!inst[31]) begin
        ctrl.vl_sel    = 1'b0;
        ctrl.vtype_sel = 1'b1;
      end else if (inst[30]) begin
        ctrl.vl_sel    = 1'b1;
        ctrl.vtype_sel = 1'b1;
      end else begin
        ctrl.vl_sel    = 1'b0;
        ctrl.vtype_sel = 1'b0;
      end
    end else begin
      ctrl.mask_operation = (inst[31:29] == 3'b011);
      ctrl.data_mux2_sel  = MUX2_VS2;
      case (funct3)
        F3_OPIVI:           ctrl.data_mux1_sel = MUX1_IMM;
        F3_OPIVX, F3_OPMVX: ctrl.data_mux1_sel = MUX1_SCAL;
        default:            ctrl.data_mux1_sel = MUX1_VS1;
      endcase
    end
  end

endmodule

// File: rtl/vec_issue_controller.sv
// Per-instruction sequencer for the vector datapath.
// Optional EXEC watchdog enabled by defining VEC_CTRL_TIMEOUT_EN.
module vec_issue_controller
  import vec_ctrl_pkg::*;
#(
  parameter int unsigned EXEC_TIMEOUT = 255,
  parameter int unsigned XLEN_P       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_valid,
  input  logic [XLEN_P-1:0] instruction,
  output logic              inst_ready,
  input  logic              is_vec,
  output logic              inst_done,
  output logic              inst_illegal,
  output logic              exec_start,
  input  logic              exec_done,
  output logic              vl_sel,
  output logic              vtype_sel,
  output logic              lumop_sel,
  output logic              rs1rd_de,
  output logic              rs1_sel,
  output logic              csrwr_en,
  output logic              vec_reg_wr_en,
  output logic              mask_operation,
  output logic              mask_wr_en,
  output logic [1:0]        data_mux1_sel,
  output logic              data_mux2_sel
);

  localparam int unsigned CNT_W = $clog2(EXEC_TIMEOUT + 1);

  vec_state_e        state_q, state_d;
  logic [XLEN_P-1:0] inst_q;
  logic              illegal_q, illegal_d;
  vec_ctrl_t         dec_ctrl, ctrl;
  logic              is_cfg, is_opv;
  logic              timeout_hit;

  vec_ctrl_decode u_decode (
    .inst   (inst_q[31:0]),
    .ctrl   (dec_ctrl),
    .is_cfg (is_cfg),
    .is_opv (is_opv)
  );

`ifdef VEC_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;

  assign timeout_hit = (state_q == S_EXEC) && !exec_done &&
                       (cnt_q == CNT_W'(EXEC_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q != S_EXEC) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt  = '0;
  assign timeout_hit = 1'b0;
`endif

  assign inst_ready = (state_q == S_IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      inst_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (inst_valid && inst_ready) begin
        inst_q <= instruction;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    ctrl          = '0;
    exec_start    = 1'b0;
    csrwr_en      = 1'b0;
    vec_reg_wr_en = 1'b0;
    mask_wr_en    = 1'b0;
    inst_done     = 1'b0;
    inst_illegal  = 1'b0;
    case (state_q)
      S_IDLE: begin
        illegal_d = 1'b0;
        if (inst_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl = dec_ctrl;
        if (!is_opv || !is_vec) begin
          state_d   = S_DONE;
          illegal_d = 1'b1;
        end else if (is_cfg) begin
          state_d = S_CFG;
        end else begin
          state_d    = S_EXEC;
          exec_start = 1'b1;
        end
      end
      S_CFG: begin
        ctrl     = dec_ctrl;
        csrwr_en = 1'b1;
        state_d  = S_DONE;
      end
      S_EXEC: begin
        ctrl = dec_ctrl;
        if (exec_done) begin
          state_d = S_WB;
        end else if (timeout_hit) begin
          state_d   = S_DONE;
          illegal_d = 1'b1;
        end
      end
      S_WB: begin
        ctrl          = dec_ctrl;
        mask_wr_en    = dec_ctrl.mask_operation;
        vec_reg_wr_en = !dec_ctrl.mask_operation;
        state_d       = S_DONE;
      end
      S_DONE: begin
        inst_done    = 1'b1;
        inst_illegal = illegal_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset overrides everything so an aborted instruction emits nothing.
    if (reset) begin
      ctrl          = '0;
      exec_start    = 1'b0;
      csrwr_en      = 1'b0;
      vec_reg_wr_en = 1'b0;
      mask_wr_en    = 1'b0;
      inst_done     = 1'b0;
      inst_illegal  = 1'b0;
    end
  end

  assign vl_sel         = ctrl.vl_sel;
  assign vtype_sel      = ctrl.vtype_sel;
  assign lumop_sel      = ctrl.lumop_sel;
  assign rs1rd_de       = ctrl.rs1rd_de;
  assign rs1_sel        = ctrl.rs1_sel;
  assign mask_operation = ctrl.mask_operation;
  assign data_mux1_sel  = ctrl.data_mux1_sel;
  assign data_mux2_sel  = ctrl.data_mux2_sel;

endmodule
